// File: rtl/factor_cu_pkg.sv
// Shared definitions for the smallest-factor control unit: FSM states,
// ALU opcodes, write-data mux selects and register-bank indices.
package factor_cu_pkg;

  typedef enum logic [3:0] {
    IDLE, LOADN, LOADD, RCOPY, OPA, OPB, SUB, INCA, INC, RES, DONE, ERR
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_INC  = 2'b11;

  localparam logic [2:0] MUX_INA   = 3'd0;
  localparam logic [2:0] MUX_INB   = 3'd1;
  localparam logic [2:0] MUX_CONST = 3'd2;
  localparam logic [2:0] MUX_ALU   = 3'd3;
  localparam logic [2:0] MUX_REG   = 3'd4;

  // R0 result, R1/R2 ALU operands, R3 N, R4 divisor, R5 running remainder
  localparam logic [3:0] R0 = 4'd0;
  localparam logic [3:0] R1 = 4'd1;
  localparam logic [3:0] R2 = 4'd2;
  localparam logic [3:0] R3 = 4'd3;
  localparam logic [3:0] R4 = 4'd4;
  localparam logic [3:0] R5 = 4'd5;

endpackage

// File: rtl/factor_cu_decode.sv
// Combinational control decode: every output is a function of state alone,
// except the remainder write in SUB, which is suppressed on borrow.
module factor_cu_decode
  import factor_cu_pkg::*;
(
  input  logic [3:0] state,
  input  logic       ALUborrow,
  output logic       WE,
  output logic [3:0] RegAdd,
  output logic [2:0] InMuxAdd,
  output logic [3:0] OutMuxAdd,
  output logic [7:0] CUconst,
  output logic [1:0] ALUop,
  output logic       busy,
  output logic       done,
  output logic       err
);

  always_comb begin
    WE        = 1'b0;
    RegAdd    = R0;
    InMuxAdd  = MUX_INA;
    OutMuxAdd = R0;
    CUconst   = 8'd0;
    ALUop     = OP_PASS;
    busy      = (state != IDLE);
    done      = 1'b0;
    err       = 1'b0;
    case (state_t'(state))
      LOADN: begin
        WE = 1'b1; RegAdd = R3; InMuxAdd = MUX_INA;
      end
      LOADD: begin
        WE = 1'b1; RegAdd = R4; InMuxAdd = MUX_CONST; CUconst = 8'd2;
      end
      RCOPY: begin
        WE = 1'b1; RegAdd = R5; InMuxAdd = MUX_REG; OutMuxAdd = R3;
      end
      OPA: begin
        WE = 1'b1; RegAdd = R1; InMuxAdd = MUX_REG; OutMuxAdd = R5;
      end
      OPB: begin
        WE = 1'b1; RegAdd = R2; InMuxAdd = MUX_REG; OutMuxAdd = R4;
      end
      SUB: begin
        // keep the old remainder when r < d so it can be discarded cleanly
        WE = ~ALUborrow; RegAdd = R5; InMuxAdd = MUX_ALU; ALUop = OP_SUB;
      end
      INCA: begin
        WE = 1'b1; RegAdd = R1; InMuxAdd = MUX_REG; OutMuxAdd = R4;
      end
      INC: begin
        WE = 1'b1; RegAdd = R4; InMuxAdd = MUX_ALU; ALUop = OP_INC;
      end
      RES: begin
        WE = 1'b1; RegAdd = R0; InMuxAdd = MUX_REG; OutMuxAdd = R4;
      end
      DONE: done = 1'b1;
      ERR: begin
        WE = 1'b1; RegAdd = R0; InMuxAdd = MUX_CONST; CUconst = 8'd0; err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/factor_cu.sv
// Smallest-factor control unit: trial division by repeated subtraction,
// driving an external register bank and 8-bit ALU one step per cycle.
module factor_cu
  import factor_cu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ALUzero,
  input  logic       ALUborrow,
  output logic       WE,
  output logic [3:0] RegAdd,
  output logic [2:0] InMuxAdd,
  output logic [3:0] OutMuxAdd,
  output logic [7:0] CUconst,
  output logic [1:0] ALUop,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else begin
      case (state)
        IDLE:  if (start) state <= LOADN;
        LOADN: state <= LOADD;
        LOADD: state <= RCOPY;
        RCOPY: state <= OPA;
        OPA:   state <= OPB;
        OPB:   state <= SUB;
        SUB: begin
          if (ALUborrow)    state <= INCA;
          else if (ALUzero) state <= RES;
          else              state <= OPA;
        end
        INCA:  state <= INC;
        // divisor wrapping to zero means every candidate up to 255 failed
        INC:   state <= ALUzero ? ERR : RCOPY;
        RES:   state <= DONE;
        DONE:  state <= IDLE;
        ERR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  factor_cu_decode u_dec (
    .state     (state),
    .ALUborrow (ALUborrow),
    .WE        (WE),
    .RegAdd    (RegAdd),
    .InMuxAdd  (InMuxAdd),
    .OutMuxAdd (OutMuxAdd),
    .CUconst   (CUconst),
    .ALUop     (ALUop),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

endmodule
